// File: rtl/tri_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tri_dispatch_pkg
// Brief    : Shared types and constants for the triangle dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package tri_dispatch_pkg;

    localparam int WORDS_PER_TRI = 12;
    localparam int NUM_VERTS     = 4;
    localparam int NUM_COORDS    = 3;
    localparam int COORD_W       = 32;
    localparam int COLOR_W       = 8;

    typedef logic [NUM_VERTS-1:0][NUM_COORDS-1:0][COORD_W-1:0] triangle_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_SHADE = 3'd3,
        ST_STORE      = 3'd4,
        ST_DONE       = 3'd5
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/tri_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tri_word_assembler
// Brief    : Streams one triangle's 12 words out of the vertex BRAM and
//            unpacks them into vertex/coordinate slots.
// Revision : 1.0 - initial release
// ============================================================================
module tri_word_assembler
    import tri_dispatch_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int BRAM_LATENCY = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               i_fetch_en,
    input  logic [ADDR_W-1:0]  i_tri_base,
    output logic               o_mem_rd_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [COORD_W-1:0] i_mem_data,
    output triangle_t          o_triangle,
    output logic               o_tri_ready
);

    localparam logic [3:0] c_num_words = 4'(WORDS_PER_TRI);
    localparam logic [1:0] c_last_vert = 2'(NUM_VERTS - 1);
    localparam logic [1:0] c_last_crd  = 2'(NUM_COORDS - 1);

    logic [3:0]              r_rd_cnt;
    logic [1:0]              r_cap_vert;
    logic [1:0]              r_cap_coord;
    logic [BRAM_LATENCY-1:0] r_vld_pipe;
    triangle_t               r_triangle;
    logic                    w_rd_en;
    logic                    w_cap_en;

    assign w_rd_en     = i_fetch_en && (r_rd_cnt != c_num_words);
    assign w_cap_en    = r_vld_pipe[BRAM_LATENCY-1];
    assign o_mem_rd_en = w_rd_en;
    assign o_mem_addr  = w_rd_en ? (i_tri_base + ADDR_W'(r_rd_cnt)) : '0;
    assign o_triangle  = r_triangle;
    // Combinational so the FSM leaves FETCH right after the last capture.
    assign o_tri_ready = w_cap_en && (r_cap_vert == c_last_vert) && (r_cap_coord == c_last_crd);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_cnt <= '0;
        end else if (!i_fetch_en) begin
            r_rd_cnt <= '0;
        end else if (w_rd_en) begin
            r_rd_cnt <= r_rd_cnt + 4'd1;
        end
    end

    generate
        if (BRAM_LATENCY == 1) begin : g_vld_lat1
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe <= w_rd_en;
                end
            end
        end else begin : g_vld_latn
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe <= {r_vld_pipe[BRAM_LATENCY-2:0], w_rd_en};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cap_vert  <= '0;
            r_cap_coord <= '0;
        end else if (!i_fetch_en) begin
            r_cap_vert  <= '0;
            r_cap_coord <= '0;
        end else if (w_cap_en) begin
            if (r_cap_coord == c_last_crd) begin
                r_cap_coord <= '0;
                r_cap_vert  <= r_cap_vert + 2'd1;
            end else begin
                r_cap_coord <= r_cap_coord + 2'd1;
            end
        end
    end

    // Held outside FETCH so the shader sees a stable triangle until STORE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_triangle <= '0;
        end else if (w_cap_en) begin
            r_triangle[r_cap_vert][r_cap_coord] <= i_mem_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/triangle_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : triangle_dispatcher
// Brief    : Stop-and-wait feeder of BRAM triangles into the pixel shader,
//            writing each returned color into a per-triangle buffer.
// Revision : 1.0 - initial release
// ============================================================================
module triangle_dispatcher
    import tri_dispatch_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int BASE_ADDR      = 0,
    parameter int BRAM_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic [15:0]        num_tri_in,
    output logic               busy_out,
    output logic               done_out,
    output logic               timeout_err_out,
    output logic               mem_rd_en_out,
    output logic [ADDR_W-1:0]  mem_addr_out,
    input  logic [COORD_W-1:0] mem_data_in,
    output logic               tri_valid_out,
    output triangle_t          triangle_out,
    input  logic               shade_valid_in,
    input  logic [COLOR_W-1:0] shade_color_in,
    output logic               color_we_out,
    output logic [15:0]        color_addr_out,
    output logic [COLOR_W-1:0] color_data_out
);

    localparam int                 c_wait_w    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

    disp_state_e          r_state;
    disp_state_e          w_next_state;
    logic [15:0]          r_num_tri;
    logic [15:0]          r_tri_idx;
    logic [ADDR_W-1:0]    r_tri_base;
    logic [c_wait_w-1:0]  r_wait_cnt;
    logic [COLOR_W-1:0]   r_color;
    logic                 r_timeout_err;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_last_tri;
    logic                 w_tri_ready;

    tri_word_assembler #(
        .ADDR_W       (ADDR_W),
        .BRAM_LATENCY (BRAM_LATENCY)
    ) u_assembler (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .i_fetch_en  (r_state == ST_FETCH),
        .i_tri_base  (r_tri_base),
        .o_mem_rd_en (mem_rd_en_out),
        .o_mem_addr  (mem_addr_out),
        .i_mem_data  (mem_data_in),
        .o_triangle  (triangle_out),
        .o_tri_ready (w_tri_ready)
    );

    assign w_last_tri = (r_tri_idx == (r_num_tri - 16'd1));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_accept     = 1'b1;
                    w_next_state = (num_tri_in == 16'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_tri_ready) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT_SHADE;
            end
            ST_WAIT_SHADE: begin
                // A result landing on the final wait cycle takes priority.
                if (shade_valid_in) begin
                    w_next_state = ST_STORE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_STORE;
                end
            end
            ST_STORE: begin
                w_next_state = w_last_tri ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_num_tri     <= '0;
            r_tri_idx     <= '0;
            r_tri_base    <= '0;
            r_wait_cnt    <= '0;
            r_color       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT_SHADE) ? (r_wait_cnt + 1'b1) : '0;
            if (w_accept) begin
                r_num_tri     <= num_tri_in;
                r_tri_idx     <= '0;
                r_tri_base    <= ADDR_W'(BASE_ADDR);
                r_timeout_err <= 1'b0;
            end
            if (r_state == ST_WAIT_SHADE) begin
                if (shade_valid_in) begin
                    r_color <= shade_color_in;
                end else if (w_timeout) begin
                    r_color       <= '0;
                    r_timeout_err <= 1'b1;
                end
            end
            if ((r_state == ST_STORE) && !w_last_tri) begin
                r_tri_idx  <= r_tri_idx + 16'd1;
                r_tri_base <= r_tri_base + ADDR_W'(WORDS_PER_TRI);
            end
        end
    end

    assign busy_out        = (r_state != ST_IDLE);
    assign done_out        = (r_state == ST_DONE);
    assign tri_valid_out   = (r_state == ST_ISSUE);
    assign color_we_out    = (r_state == ST_STORE);
    assign color_addr_out  = color_we_out ? r_tri_idx : '0;
    assign color_data_out  = color_we_out ? r_color : '0;
    assign timeout_err_out = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_triangle_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_triangle_dispatcher
// Brief    : Directed self-checking bench with BRAM and shader models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_dispatcher;
    import tri_dispatch_pkg::*;

    localparam int c_base = 100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic [15:0] num_tri_in;
    logic        busy_out, done_out, timeout_err_out;
    logic        mem_rd_en_out;
    logic [15:0] mem_addr_out;
    logic [31:0] mem_data_in;
    logic        tri_valid_out;
    triangle_t   triangle_out;
    logic        shade_valid_in;
    logic [7:0]  shade_color_in;
    logic        color_we_out;
    logic [15:0] color_addr_out;
    logic [7:0]  color_data_out;

    always #5 clk_in = ~clk_in;

    triangle_dispatcher #(
        .ADDR_W         (16),
        .BASE_ADDR      (c_base),
        .BRAM_LATENCY   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .num_tri_in      (num_tri_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .timeout_err_out (timeout_err_out),
        .mem_rd_en_out   (mem_rd_en_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_in     (mem_data_in),
        .tri_valid_out   (tri_valid_out),
        .triangle_out    (triangle_out),
        .shade_valid_in  (shade_valid_in),
        .shade_color_in  (shade_color_in),
        .color_we_out    (color_we_out),
        .color_addr_out  (color_addr_out),
        .color_data_out  (color_data_out)
    );

    // BRAM with two cycles of latency; word at c_base+k holds k+1.
    logic [15:0] bram_a1, bram_a2;
    always @(posedge clk_in) begin
        bram_a1 <= mem_addr_out;
        bram_a2 <= bram_a1;
    end
    assign mem_data_in = 32'(bram_a2) - 32'(c_base - 1);

    // Shader: replies sh_delay cycles after the strobe (0 = never) with
    // sh_color_base + low byte of the triangle's first word.
    int         sh_delay;
    logic [7:0] sh_color_base;
    logic       sh_pend = 1'b0;
    int         sh_cnt = 0;
    logic [7:0] sh_col = 8'h00;
    logic       spur;
    always @(posedge clk_in) begin
        if (tri_valid_out && sh_delay > 0) begin
            sh_pend <= 1'b1;
            sh_cnt  <= sh_delay - 1;
            sh_col  <= sh_color_base + triangle_out[0][0][7:0];
        end else if (sh_pend) begin
            if (sh_cnt == 0) sh_pend <= 1'b0;
            else             sh_cnt  <= sh_cnt - 1;
        end
    end
    assign shade_valid_in = (sh_pend && sh_cnt == 0) || spur;
    assign shade_color_in = spur ? 8'hEE : sh_col;

    // Event monitor, sampled on the falling edge.
    int          cyc = 0, acc_cyc = 0, tv_cyc = 0, wr_cyc = 0, done_cyc = 0;
    int          tv_cnt = 0, done_cnt = 0, viol = 0;
    logic        outst = 1'b0;
    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [31:0] t21_q[$];
    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (!rst_n_in) begin
            outst = 1'b0;
        end else begin
            if (start_in && !busy_out) acc_cyc = cyc;
            if (mem_rd_en_out) rd_q.push_back(mem_addr_out);
            if (tri_valid_out) begin
                if (outst) viol = viol + 1;
                outst  = 1'b1;
                tv_cnt = tv_cnt + 1;
                tv_cyc = cyc;
                t21_q.push_back(triangle_out[2][1]);
            end
            if (color_we_out) begin
                wa_q.push_back(color_addr_out);
                wd_q.push_back(color_data_out);
                wr_cyc = cyc;
                outst  = 1'b0;
            end
            if (done_out) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic start_batch(input logic [15:0] n);
        idle(1);
        num_tri_in = n;
        start_in   = 1'b1;
        idle(1);
        start_in   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk_in);
        chk_val("done_seen", done_cnt, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_busy"}, busy_out, 0);
        chk_val({tag, "_done"}, done_out, 0);
        chk_val({tag, "_rd"}, {mem_rd_en_out, mem_addr_out}, 0);
        chk_val({tag, "_tv"}, tri_valid_out, 0);
        chk_val({tag, "_tri"}, |triangle_out, 0);
        chk_val({tag, "_we"}, {color_we_out, color_addr_out, color_data_out}, 0);
        chk_val({tag, "_err"}, timeout_err_out, 0);
    endtask

    int r0, w0, t0, d0, q0, v0;
    task automatic snap();
        r0 = rd_q.size(); w0 = wa_q.size(); t0 = tv_cnt;
        d0 = done_cnt;    q0 = t21_q.size(); v0 = viol;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n_in = 1'b0; start_in = 1'b0; num_tri_in = '0; spur = 1'b0;
        sh_delay = 0; sh_color_base = 8'h00;
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        idle(1);
        rst_n_in = 1'b1;
        idle(2);

        // Single triangle, 10-cycle shader, color 8'h5A.
        sh_delay = 10; sh_color_base = 8'h59;
        snap();
        start_batch(1);
        wait_done(d0 + 1, 100);
        chk_val("t1_rd_cnt", rd_q.size() - r0, 12);
        for (int k = 0; k < 12; k++) chk_val("t1_rd_addr", rd_q[r0 + k], c_base + k);
        chk_val("t1_tv_cnt", tv_cnt - t0, 1);
        chk_val("t1_tri21", t21_q[q0], 8);
        chk_val("t1_tv_lat", tv_cyc - acc_cyc, 15);
        chk_val("t1_wr_cnt", wa_q.size() - w0, 1);
        chk_val("t1_wr_addr", wa_q[w0], 0);
        chk_val("t1_wr_data", wd_q[w0], 8'h5A);
        chk_val("t1_done_after_wr", done_cyc - wr_cyc, 1);
        idle(2);
        chk_val("t1_idle_busy", busy_out, 0);

        // Three triangles.
        sh_delay = 3; sh_color_base = 8'h30;
        snap();
        start_batch(3);
        wait_done(d0 + 1, 200);
        chk_val("t2_rd_cnt", rd_q.size() - r0, 36);
        for (int k = 0; k < 36; k++) chk_val("t2_rd_addr", rd_q[r0 + k], c_base + k);
        chk_val("t2_tv_cnt", tv_cnt - t0, 3);
        chk_val("t2_overlap", viol - v0, 0);
        chk_val("t2_tri21_t2", t21_q[q0 + 2], 32);
        chk_val("t2_wr_cnt", wa_q.size() - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk_val("t2_wr_addr", wa_q[w0 + i], i);
            chk_val("t2_wr_data", wd_q[w0 + i], 8'h30 + 8'(12 * i + 1));
        end

        // Empty batch.
        snap();
        start_batch(0);
        wait_done(d0 + 1, 20);
        chk_val("t3_done_lat", done_cyc - acc_cyc, 1);
        chk_val("t3_rd_cnt", rd_q.size() - r0, 0);
        chk_val("t3_wr_cnt", wa_q.size() - w0, 0);
        chk_val("t3_tv_cnt", tv_cnt - t0, 0);

        // Shader silent: both triangles time out.
        sh_delay = 0;
        snap();
        start_batch(2);
        wait_done(d0 + 1, 200);
        chk_val("t4_wr_cnt", wa_q.size() - w0, 2);
        chk_val("t4_wr0", {wa_q[w0], wd_q[w0]}, 24'h0000_00);
        chk_val("t4_wr1", {wa_q[w0 + 1], wd_q[w0 + 1]}, 24'h0001_00);
        chk_val("t4_wait_len", wr_cyc - tv_cyc, 17);
        idle(3);
        chk_val("t4_err_sticky", timeout_err_out, 1);

        // Result on the last wait cycle wins over the timeout.
        sh_delay = 16; sh_color_base = 8'hC0;
        snap();
        start_batch(1);
        chk_val("t4b_err_clr", timeout_err_out, 0);
        wait_done(d0 + 1, 100);
        chk_val("t4b_wr_data", wd_q[w0], 8'hC1);
        idle(2);
        chk_val("t4b_err", timeout_err_out, 0);

        // One cycle too late: timed out.
        sh_delay = 17;
        snap();
        start_batch(1);
        wait_done(d0 + 1, 100);
        chk_val("t4c_wr_data", wd_q[w0], 8'h00);
        idle(2);
        chk_val("t4c_err", timeout_err_out, 1);

        // Spurious result during FETCH and a start while busy.
        sh_delay = 4; sh_color_base = 8'h10;
        snap();
        start_batch(2);
        chk_val("t5_err_clr", timeout_err_out, 0);
        idle(3);
        spur = 1'b1; start_in = 1'b1; num_tri_in = 16'd5;
        idle(1);
        spur = 1'b0; start_in = 1'b0;
        wait_done(d0 + 1, 200);
        chk_val("t5_wr_cnt", wa_q.size() - w0, 2);
        chk_val("t5_wr0", {wa_q[w0], wd_q[w0]}, 24'h0000_11);
        chk_val("t5_wr1", {wa_q[w0 + 1], wd_q[w0 + 1]}, 24'h0001_1D);
        chk_val("t5_tv_cnt", tv_cnt - t0, 2);

        // Reset while waiting on triangle 1.
        sh_delay = 12; sh_color_base = 8'h40;
        snap();
        start_batch(2);
        for (int i = 0; i < 200 && tv_cnt < t0 + 2; i++) @(negedge clk_in);
        chk_val("t6_tv_reached", tv_cnt - t0, 2);
        idle(2);
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        idle(3);
        rst_n_in = 1'b1;
        idle(15);
        chk_val("t6_no_done", done_cnt - d0, 0);
        sh_delay = 2; sh_color_base = 8'h00;
        snap();
        start_batch(1);
        wait_done(d0 + 1, 100);
        chk_val("t6_first_rd", rd_q[r0], c_base);
        chk_val("t6_wr_cnt", wa_q.size() - w0, 1);
        chk_val("t6_wr", {wa_q[w0], wd_q[w0]}, 24'h0000_01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
